// File: rtl/binary_to_bcd_pkg.sv
// Shared constants for the sequential double-dabble binary-to-BCD converter:
// FSM state encodings, BCD digit geometry and a power-of-ten helper.
package binary_to_bcd_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam int         BCD_DIGIT_W   = 4;
    localparam logic [3:0] ADJ_THRESHOLD = 4'd5;
    localparam logic [3:0] ADJ_ADD       = 4'd3;

    // Used at elaboration time to size the saturation compare.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/binary_to_bcd_digit_adjust.sv
// One double-dabble digit cell. A digit of 5..9 becomes 8..12, which still fits
// in 4 bits, so no carry ever passes between neighbouring digits.
module bcd_digit_adjust
    import binary_to_bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] i_digit,
    output logic [BCD_DIGIT_W-1:0] o_digit
);

    always_comb begin
        o_digit = i_digit;
        if (i_digit >= ADJ_THRESHOLD) begin
            o_digit = i_digit + ADJ_ADD;
        end
    end

endmodule

// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter with a start/busy/done handshake.
// The displayed result is held stable between conversions.
module binary_to_bcd
    import binary_to_bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int DIGITS = 4
) (
    input  logic                        i_CLK,
    input  logic                        i_RST_N,
    input  logic                        i_START,
    input  logic [WIDTH-1:0]            i_BINARY,
    output logic                        o_BUSY,
    output logic                        o_DONE,
    output logic [BCD_DIGIT_W*DIGITS-1:0] o_BCD,
    output logic                        o_OVF
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam int              BCD_W    = BCD_DIGIT_W * DIGITS;
    localparam longint unsigned BCD_MAX  = pow10(DIGITS) - 1;
    // When every WIDTH-bit value fits in DIGITS decimal digits, saturation is impossible.
    localparam bit              NEED_SAT = (WIDTH >= 64) || (((64'd1 << WIDTH) - 64'd1) > BCD_MAX);

    logic [1:0]       state_q,    state_d;
    logic [WIDTH-1:0] shift_q,    shift_d;
    logic [BCD_W-1:0] scratch_q,  scratch_d;
    logic [CNT_W-1:0] cnt_q,      cnt_d;
    logic             ovf_pend_q, ovf_pend_d;
    logic [BCD_W-1:0] bcd_q,      bcd_d;
    logic             ovf_q,      ovf_d;

    logic [BCD_W-1:0] scratch_adj;
    logic             ovf_in;

    assign ovf_in = NEED_SAT && (64'(i_BINARY) > BCD_MAX);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adjust u_adj (
                .i_digit (scratch_q[gi*BCD_DIGIT_W +: BCD_DIGIT_W]),
                .o_digit (scratch_adj[gi*BCD_DIGIT_W +: BCD_DIGIT_W])
            );
        end
    endgenerate

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        scratch_d  = scratch_q;
        cnt_d      = cnt_q;
        ovf_pend_d = ovf_pend_q;
        bcd_d      = bcd_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (i_START) begin
                    shift_d    = i_BINARY;
                    scratch_d  = '0;
                    cnt_d      = CNT_W'(WIDTH);
                    ovf_pend_d = ovf_in;
                    state_d    = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                scratch_d = {scratch_adj[BCD_W-2:0], shift_q[WIDTH-1]};
                shift_d   = shift_q << 1;
                cnt_d     = cnt_q - CNT_W'(1);
                // Result is loaded on the edge into DONE so it is already valid while o_DONE is high.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                    bcd_d   = ovf_pend_q ? {DIGITS{4'h9}} : scratch_d;
                    ovf_d   = ovf_pend_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_CLK) begin
        if (!i_RST_N) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            scratch_q  <= '0;
            cnt_q      <= '0;
            ovf_pend_q <= 1'b0;
            bcd_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            scratch_q  <= scratch_d;
            cnt_q      <= cnt_d;
            ovf_pend_q <= ovf_pend_d;
            bcd_q      <= bcd_d;
            ovf_q      <= ovf_d;
        end
    end

    assign o_BUSY = (state_q != ST_IDLE);
    assign o_DONE = (state_q == ST_DONE);
    assign o_BCD  = bcd_q;
    assign o_OVF  = ovf_q;

endmodule

// File: tb/tb_binary_to_bcd.sv
// Randomized self-checking bench for binary_to_bcd against a decimal-arithmetic
// reference model; also covers latency, busy window, ignored starts and reset abort.
module tb_binary_to_bcd;

    localparam int WIDTH  = 14;
    localparam int DIGITS = 4;
    localparam int LAT    = WIDTH + 1;

    logic              clk;
    logic              rst_n;
    logic              start;
    logic [WIDTH-1:0]  binary;
    logic              busy;
    logic              done;
    logic [15:0]       bcd;
    logic              ovf;

    int n_cmp = 0;
    int n_bad = 0;

    binary_to_bcd #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .i_CLK    (clk),
        .i_RST_N  (rst_n),
        .i_START  (start),
        .i_BINARY (binary),
        .o_BUSY   (busy),
        .o_DONE   (done),
        .o_BCD    (bcd),
        .o_OVF    (ovf)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: decimal digits by division, saturating to all nines.
    function automatic logic [15:0] ref_bcd(input int v);
        logic [15:0] r;
        int          x;
        r = '0;
        if (v > 9999) return 16'h9999;
        x = v;
        for (int d = 0; d < DIGITS; d++) begin
            r[d*4 +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic conv(input int v, input string tag);
        int lat;
        int busy_cnt;
        @(negedge clk);
        start  = 1'b1;
        binary = WIDTH'(v);
        @(negedge clk);
        start    = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        forever begin
            if (busy) busy_cnt++;
            if (done || lat >= 40) break;
            @(negedge clk);
            lat++;
        end
        $display("conv %s: %0d -> bcd %h ovf %b latency %0d", tag, v, bcd, ovf, lat);
        check({tag, "_lat"}, lat, LAT);
        check({tag, "_busy"}, busy_cnt, LAT);
        check({tag, "_bcd"}, bcd, ref_bcd(v));
        check({tag, "_ovf"}, ovf, (v > 9999) ? 1 : 0);
        @(negedge clk);
        check({tag, "_done_once"}, done, 1'b0);
        check({tag, "_idle"}, busy, 1'b0);
    endtask

    initial begin
        int ndone;
        int prev;
        logic [15:0] seen;

        rst_n  = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd, 16'h0);
        check("rst_ovf", ovf, 1'b0);
        rst_n = 1'b1;

        conv(1234, "t1");
        conv(0, "t2_0");
        conv(9, "t2_9");
        conv(10, "t2_10");
        conv(9999, "t2_9999");
        conv(12000, "t3_sat");
        conv(42, "t3_after");
        conv(16383, "max");
        conv(10000, "sat_edge");

        for (int i = 0; i < 20; i++) begin
            conv(int'($urandom_range(0, 16383)), "rand");
        end

        // Start during busy is ignored; input wiggles during SHIFT are ignored.
        @(negedge clk);
        start  = 1'b1;
        binary = 14'd1234;
        ndone  = 0;
        seen   = '0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start  = (i == 5);
            binary = (i == 5) ? 14'd5678 : WIDTH'($urandom);
            if (done) begin
                ndone++;
                seen = bcd;
            end
        end
        start = 1'b0;
        $display("busy-start test: %0d done pulses, bcd %h", ndone, seen);
        check("t4_ndone", ndone, 1);
        check("t4_bcd", seen, 16'h1234);

        // Reset mid-conversion aborts without a done pulse.
        @(negedge clk);
        start  = 1'b1;
        binary = 14'd4321;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("t5_busy", busy, 1'b0);
        check("t5_bcd", bcd, 16'h0);
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        $display("reset-abort test: %0d done pulses after reset", ndone);
        check("t5_nodone", ndone, 0);
        conv(4321, "t5_fresh");

        // Start held high: back-to-back conversions at WIDTH+2 spacing.
        @(negedge clk);
        start  = 1'b1;
        binary = 14'd777;
        ndone  = 0;
        prev   = -1;
        for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (done) begin
                $display("held-start done at cycle %0d bcd %h", i, bcd);
                check("t6_bcd", bcd, 16'h0777);
                if (prev < 0) check("t6_first", i, LAT);
                else          check("t6_gap", i - prev, WIDTH + 2);
                prev = i;
                ndone++;
            end
        end
        start = 1'b0;
        check("t6_ndone", ndone, 3);
        repeat (20) @(negedge clk);
        check("t6_drain_idle", busy, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd.md
Name: binary_to_bcd

Overview:
- Sequential double-dabble converter that turns a binary score/count into packed BCD digits.
- Sits directly upstream of the per-digit binary-to-7-segment decoders; each 4-bit output nibble drives one decoder's i_BINARY.
- Handshake is start/busy/done; the result is held stable between conversions so the display never flickers mid-conversion.

Parameters:
- WIDTH, 14, bit width of the binary input; 14 covers 0..9999.
- DIGITS, 4, number of BCD output digits.

Ports:
- i_CLK  input  1  system clock (25 MHz)
- i_RST_N  input  1  synchronous, active-low reset
- i_START  input  1  request a conversion; sampled only in IDLE
- i_BINARY  input  WIDTH  unsigned value to convert; sampled on the accepted start cycle only
- o_BUSY  output  1  high whenever the state is not IDLE
- o_DONE  output  1  one-cycle pulse when o_BCD/o_OVF update
- o_BCD  output  4*DIGITS  packed result; digit 0 (units) in [3:0], digit k in [4k+3:4k]
- o_OVF  output  1  last conversion saturated

Behaviour:
- Single clock domain (i_CLK). Reset is synchronous and active-low on i_RST_N.
- Reset values (i_RST_N=0 at a rising edge):
  - state=IDLE
  - o_BUSY=0, o_DONE=0, o_BCD=0, o_OVF=0
  - internal shift/scratch registers and bit counter=0
- States:
  - IDLE:
    - When i_START=1: latch i_BINARY into the shift register, clear BCD scratch, counter=WIDTH.
    - Latch ovf_pending = (i_BINARY > 10^DIGITS-1), computed as an elaboration-time constant compare.
    - Go to SHIFT.
  - SHIFT, once per cycle:
    - Every scratch digit >=5 gets +3 (all digits in parallel).
    - Then shift {scratch, shiftreg} left by 1 and decrement counter.
    - When the counter reaches 0 after this cycle's shift, go to DONE. Exactly WIDTH cycles are spent in SHIFT.
  - DONE:
    - o_BCD <= ovf_pending ? all digits 4'h9 : scratch.
    - o_OVF <= ovf_pending; o_DONE=1 for this single cycle.
    - Go to IDLE.
- Latency:
  - Start accepted at edge N; o_DONE is high during cycle N+WIDTH+1, and o_BCD is valid from that cycle on.
  - o_BUSY is high in cycles N+1 through N+WIDTH+1.
  - Minimum start-to-start spacing is WIDTH+2 cycles.
- Hold: o_BCD and o_OVF change only in DONE; they hold through IDLE and SHIFT.
- i_START while o_BUSY=1 (SHIFT or DONE) is ignored. It is not queued and has no effect on the current result.
- i_START held high continuously: a new conversion is accepted on every IDLE cycle, i.e. back-to-back at WIDTH+2 spacing.
- i_BINARY changing during SHIFT has no effect, because the value is latched at accept.
- Saturation rule: if 2^WIDTH-1 <= 10^DIGITS-1, ovf_pending is constant 0.
- Width rule: scratch is 4*DIGITS bits. The digit-adjust add never carries between digits, since 9+3=12 still fits in 4 bits.
- Reset mid-conversion: the next edge with i_RST_N=0 forces every reset value, including o_BCD=0. No o_DONE is produced for the aborted conversion.

Decomposition:
- Shared package binary_to_bcd_pkg:
  - state encoding IDLE=2'd0, SHIFT=2'd1, DONE=2'd2
  - constants BCD_DIGIT_W=4, ADJ_THRESHOLD=4'd5, ADJ_ADD=4'd3
- One natural sub-module: bcd_digit_adjust, a combinational 4-bit in/4-bit out "if >=5 then +3" cell, instantiated DIGITS times with a generate loop.
- The FSM, counter and shift register stay in the top module.

Test Plan:
1. Reset, then i_BINARY=1234 with a 1-cycle i_START -> o_DONE pulses exactly 15 cycles after the start edge; o_BCD=16'h1234, o_OVF=0; o_BUSY high for 15 cycles.
2. Inputs 0, 9, 10, 9999 each converted in turn -> o_BCD = 16'h0000, 16'h0009, 16'h0010, 16'h9999 respectively; o_OVF=0 for all four.
3. i_BINARY=12000 -> o_BCD=16'h9999, o_OVF=1. A following conversion of 42 -> o_BCD=16'h0042, o_OVF=0.
4. Start 1234, then pulse i_START with i_BINARY=5678 at cycle +5 and change i_BINARY every cycle -> single o_DONE, o_BCD=16'h1234. No second o_DONE appears unless a new start is asserted in IDLE.
5. Start 4321, drive i_RST_N=0 at cycle +7 for one cycle -> o_BUSY=0, o_BCD=0 on the next edge, and no o_DONE within 20 cycles. A fresh start of 4321 then yields 16'h4321.
6. i_START held high for 50 cycles with i_BINARY=777 -> o_DONE pulses spaced exactly 16 cycles apart, each with o_BCD=16'h0777.
